// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared constants for the I2C master and slave stages:
//                FSM state encodings, SCL quarter-phase codes, R/W and
//                ACK/NACK bus levels.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE     = 4'd0;
    localparam state_t START    = 4'd1;
    localparam state_t ADDR     = 4'd2;
    localparam state_t ADDR_ACK = 4'd3;
    localparam state_t WR_DATA  = 4'd4;
    localparam state_t WR_ACK   = 4'd5;
    localparam state_t RD_DATA  = 4'd6;
    localparam state_t RD_ACK   = 4'd7;
    localparam state_t STOP     = 4'd8;

    typedef logic [1:0] quarter_t;

    localparam quarter_t Q0 = 2'd0;
    localparam quarter_t Q1 = 2'd1;
    localparam quarter_t Q2 = 2'd2;
    localparam quarter_t Q3 = 2'd3;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_qtick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_qtick_gen
//  Description : SCL quarter-period tick generator. Counts 0..CLK_DIV-1
//                while enabled and pulses qtick on the wrap cycle.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                en    - count enable; counter held at 0 when low
//                qtick - 1-cycle pulse at end of each quarter period
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_qtick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic qtick
);

    localparam int            CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign qtick = en && (r_cnt == C_LAST);

endmodule : i2c_qtick_gen
`default_nettype wire

// File: rtl/i2c_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_master
//  Description : Single-master I2C controller. One command per transaction:
//                START, {addr,rw}, one data byte (write or read), STOP.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start               - command strobe (ignored while busy)
//                addr, rw, wdata     - command fields, latched on accept
//                rdata               - byte received by a read
//                busy, done          - transaction in flight / end pulse
//                ack_err             - slave NACKed address or write data
//                scl                 - push-pull I2C clock
//                sda                 - open-drain I2C data
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    state_t   r_state, w_state_n;
    quarter_t r_quarter, w_quarter_n;
    logic [2:0] r_bit_cnt, w_bit_cnt_n;

    logic [7:0] r_addr_byte, r_wdata, r_shift, r_rdata;
    logic       r_busy, r_done, r_ack_err, r_sda_smp;

    logic w_qtick, w_accept, w_sample_pt, w_bit_end;
    logic w_scl, w_sda_low, w_sda_in;

    i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .en    (r_busy),
        .qtick (w_qtick)
    );

    // Master and slave share clk, so sda is sampled directly.
    assign w_sda_in = sda;

    // The done cycle is still IDLE with busy low; a strobe there is dropped.
    assign w_accept    = (r_state == IDLE) && start && !r_done;
    assign w_sample_pt = w_qtick && (r_quarter == Q1);
    assign w_bit_end   = w_qtick && (r_quarter == Q3);

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_quarter <= Q0;
            r_bit_cnt <= 3'd0;
        end else begin
            r_state   <= w_state_n;
            r_quarter <= w_quarter_n;
            r_bit_cnt <= w_bit_cnt_n;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n   = r_state;
        w_quarter_n = r_quarter;
        w_bit_cnt_n = r_bit_cnt;
        if (r_state == IDLE) begin
            w_quarter_n = Q0;
            w_bit_cnt_n = 3'd0;
            if (w_accept) begin
                w_state_n = START;
            end
        end else if (w_qtick) begin
            w_quarter_n = r_quarter + 2'd1;
            if (w_bit_end) begin
                case (r_state)
                    START:    w_state_n = ADDR;
                    ADDR: begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_state_n = ADDR_ACK;
                    end
                    ADDR_ACK: begin
                        if (r_sda_smp == NACK)                 w_state_n = STOP;
                        else if (r_addr_byte[0] == I2C_RW_READ) w_state_n = RD_DATA;
                        else                                    w_state_n = WR_DATA;
                    end
                    WR_DATA: begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_state_n = WR_ACK;
                    end
                    RD_DATA: begin
                        w_bit_cnt_n = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_state_n = RD_ACK;
                    end
                    WR_ACK, RD_ACK: w_state_n = STOP;
                    default:        w_state_n = IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus line decode (pure function of registered state)
    // ------------------------------------------------------------------
    always_comb begin
        w_scl     = 1'b1;
        w_sda_low = 1'b0;
        case (r_state)
            IDLE: begin
                w_scl     = 1'b1;
                w_sda_low = 1'b0;
            end
            START: begin
                w_scl     = (r_quarter != Q3);
                w_sda_low = (r_quarter != Q0);
            end
            STOP: begin
                w_scl     = (r_quarter != Q0);
                w_sda_low = (r_quarter == Q0) || (r_quarter == Q1);
            end
            default: begin
                w_scl = (r_quarter == Q1) || (r_quarter == Q2);
                // ~bit_cnt selects bit 7-bit_cnt: MSB first.
                if (r_state == ADDR)    w_sda_low = ~r_addr_byte[~r_bit_cnt];
                if (r_state == WR_DATA) w_sda_low = ~r_wdata[~r_bit_cnt];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, sampling, status
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_byte <= 8'h00;
            r_wdata     <= 8'h00;
            r_shift     <= 8'h00;
            r_rdata     <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack_err   <= 1'b0;
            r_sda_smp   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_addr_byte <= {addr, rw};
                r_wdata     <= wdata;
                r_ack_err   <= 1'b0;
                r_busy      <= 1'b1;
            end
            if (w_sample_pt) begin
                r_sda_smp <= w_sda_in;
                if (r_state == RD_DATA) r_shift <= {r_shift[6:0], w_sda_in};
            end
            if (w_bit_end) begin
                case (r_state)
                    ADDR_ACK, WR_ACK: if (r_sda_smp == NACK) r_ack_err <= 1'b1;
                    RD_DATA:          if (r_bit_cnt == 3'd7) r_rdata <= r_shift;
                    STOP: begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scl     = w_scl;
    assign sda     = w_sda_low ? 1'b0 : 1'bz;
    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;

endmodule : i2c_master
`default_nettype wire

// File: tb/tb_i2c_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_master
//  Description : Self-checking bench for i2c_master with a bus-level slave
//                model and a byte scoreboard ({byte, ack-bit} entries).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_master;

    localparam int CLK_DIV = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] addr  = 7'h00;
    logic       rw    = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, ack_err, scl;
    wire        sda;

    logic slave_low = 1'b0;
    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    int errors = 0;
    int checks = 0;

    logic [8:0] sb[$];
    int   start_cnt = 0;
    int   stop_cnt  = 0;
    logic addr_ack_en = 1'b1;
    logic [7:0] rd_byte = 8'h00;

    i2c_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .addr    (addr),
        .rw      (rw),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Bus monitor + slave model, evaluated mid-cycle
    // ------------------------------------------------------------------
    logic       m_prev_scl = 1'b1;
    logic       m_prev_sda = 1'b1;
    logic       m_in_txn   = 1'b0;
    logic       m_rw       = 1'b0;
    int         m_bit      = 0;
    int         m_byte     = 0;
    logic [8:0] m_sh       = 9'h0;

    always @(negedge clk) begin
        if (reset) begin
            m_in_txn  = 1'b0;
            slave_low = 1'b0;
        end else if (scl && m_prev_scl && m_prev_sda && !sda) begin
            start_cnt++;
            m_in_txn = 1'b1;
            m_bit    = 0;
            m_byte   = 0;
            m_sh     = 9'h0;
        end else if (scl && m_prev_scl && !m_prev_sda && sda) begin
            stop_cnt++;
            m_in_txn  = 1'b0;
            slave_low = 1'b0;
        end else if (m_in_txn && scl && !m_prev_scl) begin
            m_sh = {m_sh[7:0], sda};
            m_bit++;
            if (m_bit == 9) begin
                if (m_byte == 0) m_rw = m_sh[1];
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_byte: observed=0x%0h expected=none", m_sh);
                end else begin
                    check("bus_byte_ack", 32'(m_sh), 32'(sb.pop_front()));
                end
                m_bit = 0;
                m_byte++;
            end
        end else if (m_in_txn && !scl && m_prev_scl) begin
            if (m_bit == 8 && m_byte == 0)               slave_low = addr_ack_en;
            else if (m_bit == 8 && m_byte == 1 && !m_rw) slave_low = 1'b1;
            else if (m_byte == 1 && m_rw && m_bit < 8)   slave_low = !rd_byte[7 - m_bit];
            else                                         slave_low = 1'b0;
        end
        m_prev_scl = scl;
        m_prev_sda = sda;
    end

    // ------------------------------------------------------------------
    // One transaction: strobe, wait for done with a bound, check status
    // ------------------------------------------------------------------
    task automatic run_txn(input string tag, input logic [6:0] a, input logic r,
                           input logic [7:0] wd, input int exp_lat, input logic exp_err,
                           input logic [7:0] exp_rd, input bit collide);
        int n;
        bit seen;
        bit busy_ok;
        int s0;
        int p0;
        s0 = start_cnt;
        p0 = stop_cnt;
        @(negedge clk);
        addr = a; rw = r; wdata = wd; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        n       = 1;
        seen    = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < 200 * CLK_DIV) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (collide && n == 100) begin
                    addr = 7'h11; rw = 1'b1; wdata = 8'hFF; start = 1'b1;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"},   32'(n), 32'(exp_lat));
        check({tag, "_ack_err"},   32'(ack_err), 32'(exp_err));
        check({tag, "_busy_low"},  32'(busy), 32'd0);
        check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
        check({tag, "_starts"},    32'(start_cnt), 32'(s0 + 1));
        check({tag, "_stops"},     32'(stop_cnt), 32'(p0 + 1));
        check({tag, "_sb_empty"},  32'(sb.size()), 32'd0);
        if (r) check({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        if (collide) begin
            addr = 7'h11; rw = 1'b0; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        if (collide) begin
            repeat (20) @(posedge clk);
            #1;
            check({tag, "_done_cycle_start_ignored"}, 32'(busy), 32'd0);
            check({tag, "_no_new_start"}, 32'(start_cnt), 32'(s0 + 1));
        end
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_scl",     32'(scl), 32'd1);
        check("rst_sda",     32'(sda), 32'd1);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_rdata",   32'(rdata), 32'h00);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            check("idle_done", 32'(done), 32'd0);
        end
        check("idle_scl",  32'(scl), 32'd1);
        check("idle_sda",  32'(sda), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);

        // Write 0x42 <- 0xA5, both bytes ACKed
        sb.push_back({8'h84, 1'b0});
        sb.push_back({8'hA5, 1'b0});
        run_txn("write", 7'h42, 1'b0, 8'hA5, 80 * CLK_DIV + 1, 1'b0, 8'h00, 1'b0);

        // Read from 0x50, slave returns 0x3C, master NACKs
        rd_byte = 8'h3C;
        sb.push_back({8'hA1, 1'b0});
        sb.push_back({8'h3C, 1'b1});
        run_txn("read", 7'h50, 1'b1, 8'h00, 80 * CLK_DIV + 1, 1'b0, 8'h3C, 1'b0);

        // Address NACK: no data byte, early STOP
        addr_ack_en = 1'b0;
        sb.push_back({8'hFE, 1'b1});
        run_txn("addr_nack", 7'h7F, 1'b0, 8'h99, 44 * CLK_DIV + 1, 1'b1, 8'h00, 1'b0);
        addr_ack_en = 1'b1;

        // Command collision mid-transaction and in the done cycle
        sb.push_back({8'h84, 1'b0});
        sb.push_back({8'h5A, 1'b0});
        run_txn("collide", 7'h42, 1'b0, 8'h5A, 80 * CLK_DIV + 1, 1'b0, 8'h00, 1'b1);

        // Reset during ADDR bit 3 (bit value 0 of 0x84, mid-high)
        @(negedge clk);
        addr = 7'h42; rw = 1'b0; wdata = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (69) @(posedge clk);
        #1;
        check("midbyte_scl", 32'(scl), 32'd1);
        check("midbyte_sda", 32'(sda), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_scl",  32'(scl), 32'd1);
        check("abort_sda",  32'(sda), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        repeat (5) @(posedge clk);

        // Normal write after the abort
        sb.push_back({8'h84, 1'b0});
        sb.push_back({8'hC3, 1'b0});
        run_txn("post_reset", 7'h42, 1'b0, 8'hC3, 80 * CLK_DIV + 1, 1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2c_master
`default_nettype wire

// File: doc/i2c_master.md
Name: i2c_master

Overview:
Single-master I2C controller that generates the bus traffic consumed by the I2C slave stage on the same sda/scl pair.
- Accepts one command per transaction from the host side: 7-bit address, R/W bit, and one write byte.
- Produces START, address byte, one data byte (write or read), and STOP.
- Reports completion, read data, and ACK errors back to the host.

Parameters:
CLK_DIV, 4, clk cycles per SCL quarter-period (min 2); one SCL bit = 4*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  1-cycle command strobe; sampled only when busy=0.
addr  input  7  target slave address; captured on accepted start.
rw  input  1  0=write, 1=read; captured on accepted start.
wdata  input  8  write byte; captured on accepted start.
rdata  output  8  byte received in a read transaction.
busy  output  1  high from accept cycle until done pulse.
done  output  1  1-cycle pulse at end of transaction.
ack_err  output  1  slave NACKed address or write data; valid with done, held until next accept.
scl  output  1  I2C clock, push-pull, no clock-stretch support.
sda  inout  1  open-drain: driven 0 or released to Z, never driven 1.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: scl=1, sda released (Z), busy=0, done=0, ack_err=0, rdata=0x00, state=IDLE, quarter counter=0.
- Reset mid-transaction: lines are released on the next clk edge; no STOP is generated.
- Quarter tick: a counter runs 0..CLK_DIV-1 while busy and emits qtick at wrap. Every phase advance happens on qtick.
- States: IDLE, START, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, STOP.
- Each state except IDLE spans 4 quarters (q0..q3) per bit.
- IDLE: scl=1, sda=Z.
  - start=1 latches {addr,rw,wdata}, clears ack_err, sets busy, enters START.
  - start while busy is ignored; inputs are not re-latched.
- START:
  - q0: scl=1, sda=Z.
  - q1, q2: sda=0 with scl=1 (start condition).
  - q3: scl=0.
  - Then ADDR.
- Bit timing (ADDR/WR_DATA/RD_DATA/ack states):
  - q0: scl=0, drive next sda value.
  - q1, q2: scl=1.
  - q3: scl=0.
  - Receiver sample point is the end of q1 (mid-high).
- ADDR: 8 bits MSB first = {addr, rw}; bit counter 0..7, then ADDR_ACK.
- ADDR_ACK: sda=Z, sample at end of q1.
  - sample=1 (NACK): ack_err=1, go to STOP.
  - Else go to WR_DATA if rw=0, RD_DATA if rw=1.
- WR_DATA: 8 bits of latched wdata, MSB first, then WR_ACK.
- WR_ACK: sda=Z, sample. NACK sets ack_err=1. Always go to STOP.
- RD_DATA: sda=Z. Shift the sampled bit into a shift register MSB first. After bit 7, rdata <= shift register, then RD_ACK.
- RD_ACK: master NACKs (sda=Z for the whole bit), then STOP.
- STOP:
  - q0: scl=0, sda=0.
  - q1: scl=1, sda=0.
  - q2: sda=Z while scl=1 (stop condition).
  - q3: idle.
  - At end of q3: done=1 for 1 cycle, busy=0, go to IDLE.
- Latency from accepted start to done:
  - Full transaction: 80*CLK_DIV+1 clk (START 4 + 9 bits + 9 bits + STOP 4 quarters).
  - Address NACK: 44*CLK_DIV+1 clk.
- A start asserted in the same cycle as done is ignored; it is accepted the next cycle when busy=0.
- Bit counter is 3 bits wide and wraps 7->0 on byte end; no other counter may overflow.

Decomposition:
- Shared package i2c_pkg:
  - state localparams (IDLE..STOP);
  - quarter-phase constants Q0..Q3;
  - I2C_RW_WRITE=0, I2C_RW_READ=1;
  - ACK=0, NACK=1.
  - The slave stage uses the same constants.
- Sub-module i2c_qtick_gen(clk, reset, en, qtick) with parameter CLK_DIV: quarter-period tick generator, counter cleared when en=0.

Test Plan:
- Idle after reset: hold reset 3 cycles, release, 50 cycles -> scl=1, sda=Z, busy=0, done never pulses.
- Write, CLK_DIV=4: addr=0x42, rw=0, wdata=0xA5, bus model ACKs both bytes.
  - START seen, then sda bits 0x84, ACK, then 0xA5, ACK, then STOP.
  - done exactly 321 clk after the start strobe; ack_err=0.
- Read: addr=0x50, rw=1, bus model ACKs address and drives 0x3C.
  - Bits 0xA1 on bus; rdata=0x3C at done.
  - sda stays Z during the 9th data bit (master NACK); ack_err=0.
- Address NACK: addr=0x7F, model leaves sda high on ack bit.
  - STOP follows immediately, no data byte on bus.
  - done 177 clk after the strobe, ack_err=1.
- Command collision: assert start with addr=0x11 mid-transaction, and again in the done cycle.
  - Both are ignored: bus carries only the original address, busy stays high until done.
- Reset mid-byte: assert reset during ADDR bit 3.
  - Next clk: scl=1, sda=Z, busy=0, done=0.
  - A new write transaction afterwards completes normally.
